execute_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline. Sits between the ID/EX register and the memory-access stage.
- Selects ALU operands and computes ALU result, zero flag and branch target.
- Runs iterative MULT/DIV into HI/LO, holding the pipeline with a stall until the operation completes.
- Outputs are registered (EX/MEM register inside this block) and drive the memory-access stage directly.

---
 rtl/execute_pkg.sv | 29 ++
 rtl/execute_muldiv_unit.sv | 141 ++++++++++++++
 rtl/execute_stage.sv | 165 ++++++++++++++++
 tb/tb_execute_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared types for the MIPS execute stage: ALU op codes, HI/LO read select, mul/div FSM states.
package execute_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_LUI   = 4'd11,
        OP_MULT  = 4'd12,
        OP_MULTU = 4'd13,
        OP_DIV   = 4'd14,
        OP_DIVU  = 4'd15
    } alu_op_t;

    localparam logic [1:0] HILO_ALU = 2'b00;
    localparam logic [1:0] HILO_HI  = 2'b01;
    localparam logic [1:0] HILO_LO  = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO.
// FAST_MUL_EN: MULT/MULTU use a single-cycle combinational product instead of the loop.
module muldiv_unit
    import execute_pkg::*;
#(
    parameter int MD_ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        md_req,
    input  logic [1:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        idle
);

    localparam int CW = $clog2(MD_ITER) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_ITER - 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   dvs_q, dvs_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, dz_q, dz_d;

    logic          signed_op, fast_mul;
    logic [31:0]   mag_a, mag_b;
    logic [32:0]   mul_sum, rem_sh, rem_diff;
    logic          rem_ge;
    logic [63:0]   step, fast_prod;

    assign signed_op = ~md_op[0];
    assign mag_a = (signed_op && op_a[31]) ? -op_a : op_a;
    assign mag_b = (signed_op && op_b[31]) ? -op_b : op_b;

`ifdef FAST_MUL_EN
    logic signed [65:0] fa, fb, fp;
    assign fa = {{34{signed_op & op_a[31]}}, op_a};
    assign fb = {{34{signed_op & op_b[31]}}, op_b};
    assign fp = fa * fb;
    assign fast_prod = fp[63:0];
    assign fast_mul  = ~md_op[1];
`else
    assign fast_prod = '0;
    assign fast_mul  = 1'b0;
`endif

    // acc holds {partial product, multiplier} or {remainder, quotient}
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    assign rem_sh   = acc_q[63:31];
    assign rem_ge   = rem_sh >= {1'b0, dvs_q};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign step = is_div_q ? (rem_ge ? {rem_diff[31:0], acc_q[30:0], 1'b1}
                                     : {rem_sh[31:0], acc_q[30:0], 1'b0})
                           : {mul_sum, acc_q[31:1]};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (md_req) begin
                    if (fast_mul) begin
                        hi_d    = fast_prod[63:32];
                        lo_d    = fast_prod[31:0];
                        state_d = DONE;
                    end else begin
                        is_div_d = md_op[1];
                        neg_lo_d = signed_op & (op_a[31] ^ op_b[31]);
                        neg_hi_d = signed_op & op_a[31];
                        dz_d     = (op_b == 32'd0);
                        acc_d    = {32'd0, md_op[1] ? mag_a : mag_b};
                        dvs_d    = md_op[1] ? mag_b : mag_a;
                        count_d  = '0;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d   = step;
                count_d = count_q + 1'b1;
                if (count_q == CNT_LAST) begin
                    state_d = DONE;
                    if (is_div_q) begin
                        // divide by zero keeps the dividend as remainder; quotient saturates to all ones
                        lo_d = dz_q ? '1 : (neg_lo_q ? -step[31:0] : step[31:0]);
                        hi_d = neg_hi_q ? -step[63:32] : step[63:32];
                    end else begin
                        {hi_d, lo_d} = neg_lo_q ? -step : step;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == BUSY);
    assign idle = (state_q == IDLE);

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: ALU, operand/result muxes, mul/div stall and the EX/MEM register.
// FAST_MUL_EN (see muldiv_unit) shortens the MULT/MULTU stall to one cycle.
module execute_stage
    import execute_pkg::*;
#(
    parameter int MD_ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    input  logic [31:0] sign_ext_imm,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  shamt,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic [3:0]  alu_op,
    input  logic [1:0]  hilo_sel,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        Branch_in,
    input  logic        MemToReg_in,
    input  logic        RegWrite_in,
    input  logic [2:0]  trunk_mode_in,
    output logic        stall,
    output logic [31:0] alu_result,
    output logic [31:0] in_data,
    output logic [31:0] branch_target,
    output logic [4:0]  reg_dest,
    output logic        zero_signal,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        Branch,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic [2:0]  trunk_mode
);

    logic [31:0] op_a, op_b, alu_res, ex_res, hi, lo;
    logic        is_md, md_busy, md_idle;

    logic [31:0] alu_result_q, alu_result_d, in_data_q, in_data_d, branch_target_q, branch_target_d;
    logic [4:0]  reg_dest_q, reg_dest_d;
    logic [2:0]  trunk_mode_q, trunk_mode_d;
    logic        zero_q, zero_d, mem_write_q, mem_write_d, mem_read_q, mem_read_d;
    logic        branch_q, branch_d, mem_to_reg_q, mem_to_reg_d, reg_write_q, reg_write_d;

    assign op_a  = read_data_1;
    assign op_b  = ALUSrc ? sign_ext_imm : read_data_2;
    assign is_md = alu_op[3] & alu_op[2];

    muldiv_unit #(.MD_ITER(MD_ITER)) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .md_req (is_md),
        .md_op  (alu_op[1:0]),
        .op_a   (op_a),
        .op_b   (op_b),
        .hi     (hi),
        .lo     (lo),
        .busy   (md_busy),
        .idle   (md_idle)
    );

    // the issuing cycle stalls too, so upstream holds the md op until DONE
    assign stall = (md_idle & is_md) | md_busy;

    always_comb begin
        alu_res = '0;
        case (alu_op_t'(alu_op))
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {31'd0, op_a < op_b};
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_SRA:  alu_res = $signed(op_b) >>> shamt;
            OP_LUI:  alu_res = {op_b[15:0], 16'd0};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (hilo_sel)
            HILO_HI:  ex_res = hi;
            HILO_LO:  ex_res = lo;
            HILO_ALU: ex_res = alu_res;
            default:  ex_res = alu_res;
        endcase
    end

    always_comb begin
        alu_result_d    = ex_res;
        zero_d          = (ex_res == 32'd0);
        branch_target_d = pc_plus4 + {sign_ext_imm[29:0], 2'b00};
        in_data_d       = read_data_2;
        reg_dest_d      = RegDst ? rd : rt;
        mem_write_d     = MemWrite_in;
        mem_read_d      = MemRead_in;
        branch_d        = Branch_in;
        mem_to_reg_d    = MemToReg_in;
        reg_write_d     = RegWrite_in & ~is_md;
        trunk_mode_d    = trunk_mode_in;
        if (stall) begin
            alu_result_d    = '0;
            zero_d          = 1'b0;
            branch_target_d = '0;
            in_data_d       = '0;
            reg_dest_d      = '0;
            mem_write_d     = 1'b0;
            mem_read_d      = 1'b0;
            branch_d        = 1'b0;
            mem_to_reg_d    = 1'b0;
            reg_write_d     = 1'b0;
            trunk_mode_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_result_q    <= '0;
            zero_q          <= 1'b0;
            branch_target_q <= '0;
            in_data_q       <= '0;
            reg_dest_q      <= '0;
            mem_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            branch_q        <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            reg_write_q     <= 1'b0;
            trunk_mode_q    <= '0;
        end else begin
            alu_result_q    <= alu_result_d;
            zero_q          <= zero_d;
            branch_target_q <= branch_target_d;
            in_data_q       <= in_data_d;
            reg_dest_q      <= reg_dest_d;
            mem_write_q     <= mem_write_d;
            mem_read_q      <= mem_read_d;
            branch_q        <= branch_d;
            mem_to_reg_q    <= mem_to_reg_d;
            reg_write_q     <= reg_write_d;
            trunk_mode_q    <= trunk_mode_d;
        end
    end

    assign alu_result    = alu_result_q;
    assign zero_signal   = zero_q;
    assign branch_target = branch_target_q;
    assign in_data       = in_data_q;
    assign reg_dest      = reg_dest_q;
    assign MemWrite      = mem_write_q;
    assign MemRead       = mem_read_q;
    assign Branch        = branch_q;
    assign MemToReg      = mem_to_reg_q;
    assign RegWrite      = reg_write_q;
    assign trunk_mode    = trunk_mode_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a per-cycle reference model of EX/MEM outputs and stall.
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] read_data_1, read_data_2, sign_ext_imm, pc_plus4;
    logic [4:0]  shamt, rt, rd;
    logic        RegDst, ALUSrc;
    logic [3:0]  alu_op;
    logic [1:0]  hilo_sel;
    logic        MemWrite_in, MemRead_in, Branch_in, MemToReg_in, RegWrite_in;
    logic [2:0]  trunk_mode_in;
    logic        stall;
    logic [31:0] alu_result, in_data, branch_target;
    logic [4:0]  reg_dest;
    logic        zero_signal, MemWrite, MemRead, Branch, MemToReg, RegWrite;
    logic [2:0]  trunk_mode;

    int n_vec = 0;
    int n_err = 0;

    execute_stage dut (
        .clock(clock), .reset(reset),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .sign_ext_imm(sign_ext_imm), .pc_plus4(pc_plus4), .shamt(shamt),
        .rt(rt), .rd(rd), .RegDst(RegDst), .ALUSrc(ALUSrc),
        .alu_op(alu_op), .hilo_sel(hilo_sel),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .Branch_in(Branch_in),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .trunk_mode_in(trunk_mode_in),
        .stall(stall), .alu_result(alu_result), .in_data(in_data),
        .branch_target(branch_target), .reg_dest(reg_dest), .zero_signal(zero_signal),
        .MemWrite(MemWrite), .MemRead(MemRead), .Branch(Branch), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .trunk_mode(trunk_mode)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input int sh);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~(a | b);
            6:  return (sa < sb) ? 32'd1 : 32'd0;
            7:  return (a < b) ? 32'd1 : 32'd0;
            8:  return b << sh;
            9:  return b >> sh;
            10: return sb >>> sh;
            11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int m_lat(input int op);
`ifdef FAST_MUL_EN
        if (op == 12 || op == 13) return 1;
`endif
        return 33;
    endfunction

    task automatic m_md(input int op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l);
        longint p;
        logic [63:0] u;
        int sa, sb;
        sa = a;
        sb = b;
        h = 0;
        l = 0;
        if (op == 12) begin
            p = longint'(sa) * longint'(sb);
            {h, l} = p;
        end else if (op == 13) begin
            u = {32'd0, a} * {32'd0, b};
            {h, l} = u;
        end else if (b == 0) begin
            l = 32'hFFFF_FFFF;
            h = a;
        end else if (op == 14) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = 32'h8000_0000;
                h = 0;
            end else begin
                l = sa / sb;
                h = sa % sb;
            end
        end else begin
            l = a / b;
            h = a % b;
        end
    endtask

    int          m_left = 0;
    bit          m_done = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi, p_lo;

    always @(posedge clock or posedge reset) begin
        logic        s_stall, e_stall, chk_data, md;
        logic [31:0] e_alu, e_bt, e_in, opb;
        logic [4:0]  e_rd;
        logic [2:0]  e_tm;
        logic        e_zero, e_mw, e_mr, e_br, e_m2r, e_rw;
        if (reset) begin
            m_left = 0;
            m_done = 0;
            m_hi   = 0;
            m_lo   = 0;
            #1;
            chk("reset_outputs", {alu_result | in_data | branch_target},  32'd0);
            chk("reset_ctrl", {reg_dest, trunk_mode, zero_signal, MemWrite, MemRead, Branch,
                               MemToReg, RegWrite}, 32'd0);
        end else begin
            s_stall = stall;
            md  = (alu_op >= 4'd12);
            opb = ALUSrc ? sign_ext_imm : read_data_2;
            if (md && !m_done && m_left == 0) begin
                m_left = m_lat(int'(alu_op));
                m_md(int'(alu_op), read_data_1, opb, p_hi, p_lo);
            end
            e_stall = (m_left > 0);
            chk_data = 1;
            if (e_stall) begin
                {e_alu, e_bt, e_in, e_rd, e_tm} = '0;
                {e_zero, e_mw, e_mr, e_br, e_m2r, e_rw} = '0;
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1;
                end
            end else begin
                e_alu = (hilo_sel == 2'b01) ? m_hi :
                        (hilo_sel == 2'b10) ? m_lo :
                        m_alu(int'(alu_op), read_data_1, opb, int'(shamt));
                e_zero = (e_alu == 0);
                e_bt  = pc_plus4 + sign_ext_imm * 4;
                e_in  = read_data_2;
                e_rd  = RegDst ? rd : rt;
                e_tm  = trunk_mode_in;
                e_mw  = MemWrite_in;
                e_mr  = MemRead_in;
                e_br  = Branch_in;
                e_m2r = MemToReg_in;
                e_rw  = RegWrite_in && !md;
                chk_data = !md;
                m_done = 0;
            end
            #1;
            chk("stall", {31'd0, s_stall}, {31'd0, e_stall});
            if (chk_data) begin
                chk("alu_result", alu_result, e_alu);
                chk("zero_signal", {31'd0, zero_signal}, {31'd0, e_zero});
            end
            chk("branch_target", branch_target, e_bt);
            chk("in_data", in_data, e_in);
            chk("ctrl", {reg_dest, trunk_mode, MemWrite, MemRead, Branch, MemToReg, RegWrite},
                {e_rd, e_tm, e_mw, e_mr, e_br, e_m2r, e_rw});
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_nop();
        read_data_1 = 0; read_data_2 = 0; sign_ext_imm = 0; pc_plus4 = 0;
        shamt = 0; rt = 0; rd = 0; RegDst = 0; ALUSrc = 0; alu_op = 0; hilo_sel = 0;
        MemWrite_in = 0; MemRead_in = 0; Branch_in = 0; MemToReg_in = 0; RegWrite_in = 0;
        trunk_mode_in = 0;
    endtask

    // called just after a negedge with inputs set; returns after the capturing edge
    task automatic run(output int stalls);
        stalls = 0;
        forever begin
            #1;
            if (!stall) break;
            @(posedge clock);
            stalls++;
            @(negedge clock);
            if (stalls > 100) begin
                n_vec++;
                n_err++;
                $display("FAIL stall_timeout: got %0d cycles expected at most 33", stalls);
                break;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic read_hilo(input logic [1:0] sel, input string name, input logic [31:0] exp);
        int st;
        set_nop();
        hilo_sel = sel;
        RegWrite_in = 1;
        rt = 5'd3;
        run(st);
        chk(name, alu_result, exp);
    endtask

    task automatic md_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_st, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input string name);
        int st;
        set_nop();
        alu_op = op;
        read_data_1 = a;
        read_data_2 = b;
        RegWrite_in = 1;
        rd = 5'd9;
        RegDst = 1;
        run(st);
        chk({name, "_stall_cycles"}, st, exp_st);
        chk({name, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
        read_hilo(2'b01, {name, "_hi"}, exp_hi);
        read_hilo(2'b10, {name, "_lo"}, exp_lo);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm;
        logic        src;
        logic [4:0]  sh;
        logic [1:0]  hs;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [14];
    int   mul_st;

    initial begin
        tbl = '{
            '{4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 5'd0,  2'b00, 32'h0000_0000},
            '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         1'b0, 5'd0,  2'b00, 32'hF000_F000},
            '{4'd3,  32'h0F0F_0000, 32'h0000_00FF, 32'h0,         1'b0, 5'd0,  2'b00, 32'h0F0F_00FF},
            '{4'd4,  32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0,         1'b0, 5'd0,  2'b00, 32'hF00F_0FF0},
            '{4'd5,  32'h0,         32'h0,         32'h0,         1'b0, 5'd0,  2'b00, 32'hFFFF_FFFF},
            '{4'd6,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 5'd0,  2'b00, 32'h0000_0001},
            '{4'd7,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 5'd0,  2'b00, 32'h0000_0000},
            '{4'd8,  32'h0,         32'h1,         32'h0,         1'b0, 5'd31, 2'b00, 32'h8000_0000},
            '{4'd9,  32'h0,         32'h8000_0000, 32'h0,         1'b0, 5'd4,  2'b00, 32'h0800_0000},
            '{4'd10, 32'h0,         32'h8000_0000, 32'h0,         1'b0, 5'd4,  2'b00, 32'hF800_0000},
            '{4'd11, 32'h0,         32'hDEAD_0000, 32'h0000_1234, 1'b1, 5'd0,  2'b00, 32'h1234_0000},
            '{4'd0,  32'd20,        32'h0,         32'hFFFF_FFF0, 1'b1, 5'd0,  2'b00, 32'h0000_0004},
            '{4'd0,  32'd2,         32'd3,         32'h0,         1'b0, 5'd0,  2'b11, 32'h0000_0005},
            '{4'd1,  32'd3,         32'd5,         32'h0,         1'b0, 5'd0,  2'b00, 32'hFFFF_FFFE}
        };
        set_nop();
        repeat (2) @(negedge clock);
        reset = 0;

        foreach (tbl[i]) begin
            int st;
            set_nop();
            alu_op = tbl[i].op; read_data_1 = tbl[i].a; read_data_2 = tbl[i].b;
            sign_ext_imm = tbl[i].imm; ALUSrc = tbl[i].src; shamt = tbl[i].sh;
            hilo_sel = tbl[i].hs; RegWrite_in = 1; RegDst = i[0];
            rt = 5'(i); rd = 5'(31 - i); pc_plus4 = 32'h40 * i;
            run(st);
            chk("alu_vec", alu_result, tbl[i].exp);
        end

        begin
            int st;
            set_nop();
            alu_op = 4'd1; read_data_1 = 5; read_data_2 = 5; Branch_in = 1;
            pc_plus4 = 32'h100; sign_ext_imm = 32'hFFFF_FFFF;
            run(st);
            chk("beq_branch", {31'd0, Branch}, 32'd1);
            chk("beq_zero", {31'd0, zero_signal}, 32'd1);
            chk("beq_target", branch_target, 32'h0000_00FC);
        end

`ifdef FAST_MUL_EN
        mul_st = 1;
`else
        mul_st = 33;
`endif
        md_op(4'd12, 32'hFFFF_FFFE, 32'd3, mul_st, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");

        // asynchronous reset with nonzero outputs (last MFLO left alu_result nonzero)
        #2;
        reset = 1;
        #1;
        chk("async_alu", alu_result, 32'd0);
        chk("async_rd", {27'd0, reg_dest}, 32'd0);
        @(negedge clock);
        reset = 0;
        read_hilo(2'b01, "reset_hi", 32'd0);
        read_hilo(2'b10, "reset_lo", 32'd0);

        md_op(4'd15, 32'd100, 32'd0, 33, 32'd100, 32'hFFFF_FFFF, "divu_by0");
        md_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, "div_ovf");
        md_op(4'd14, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        md_op(4'd14, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0");

        // reset while DIVU 50/7 sits at iteration 10
        set_nop();
        alu_op = 4'd15; read_data_1 = 50; read_data_2 = 7;
        repeat (11) @(posedge clock);
        @(negedge clock);
        #2;
        set_nop();
        reset = 1;
        #1;
        chk("midreset_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 0;
        read_hilo(2'b01, "midreset_hi", 32'd0);
        read_hilo(2'b10, "midreset_lo", 32'd0);
        md_op(4'd15, 32'd50, 32'd7, 33, 32'd1, 32'd7, "divu_reissue");

        md_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mul_st, 32'hFFFF_FFFE, 32'h0000_0001, "multu");

        begin
            int st;
            set_nop();
            alu_op = 4'd0; read_data_1 = 32'h1000; sign_ext_imm = 8; ALUSrc = 1;
            read_data_2 = 32'hDEAD_BEEF; MemWrite_in = 1; trunk_mode_in = 3'b010; rt = 5'd7;
            run(st);
            chk("store_stall_cycles", st, 32'd0);
            chk("store_addr", alu_result, 32'h0000_1008);
            chk("store_data", in_data, 32'hDEAD_BEEF);
            chk("store_ctrl", {27'd0, MemWrite, RegWrite, trunk_mode}, 32'b1_0_010);
        end

        set_nop();
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
